// File: rtl/decode_queue.sv
// RV32I decode stage: decodes fetched instructions on entry and buffers the
// decoded fields in a DEPTH-entry FIFO presented to issue with valid/stall.
module decode_queue #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        flush_in,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_inst,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_pred,
   output logic        fetch_ready,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        RS_full,
   input  logic        LSB_full,
   input  logic        RoB_full,
   input  logic        RoB_stall,
   output logic        issue_valid,
   output logic        issue_stall,
   output logic [6:0]  issue_opcode,
   output logic [4:0]  issue_rd,
   output logic [4:0]  issue_rs1,
   output logic [4:0]  issue_rs2,
   output logic [2:0]  issue_funct3,
   output logic        issue_funct7,
   output logic [31:0] issue_imm,
   output logic [31:0] issue_pc,
   output logic        issue_pred,
   output logic [31:0] issue_pc_B_fail,
   output logic        issue_need_LSB,
   output logic        issue_illegal
);

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic        funct7;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        pred;
      logic [31:0] pc_b_fail;
      logic        need_lsb;
      logic        illegal;
   } entry_t;

   entry_t           dec_entry;
   entry_t           head_entry;
   entry_t           slot_q [DEPTH];
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [PTR_W:0]   count_reg, count_next;
   logic             enq, deq;

   always_comb begin
      dec_entry        = '0;
      dec_entry.opcode = fetch_inst[6:0];
      dec_entry.rd     = fetch_inst[11:7];
      dec_entry.funct3 = fetch_inst[14:12];
      dec_entry.rs1    = fetch_inst[19:15];
      dec_entry.rs2    = fetch_inst[24:20];
      dec_entry.funct7 = fetch_inst[30];
      dec_entry.pc     = fetch_pc;
      dec_entry.pred   = fetch_pred;
      case (fetch_inst[6:0])
         OP_LUI, OP_AUIPC: dec_entry.imm = {fetch_inst[31:12], 12'b0};
         OP_JAL:    dec_entry.imm = {{12{fetch_inst[31]}}, fetch_inst[19:12],
                                     fetch_inst[20], fetch_inst[30:21], 1'b0};
         OP_BRANCH: dec_entry.imm = {{20{fetch_inst[31]}}, fetch_inst[7],
                                     fetch_inst[30:25], fetch_inst[11:8], 1'b0};
         OP_STORE:  dec_entry.imm = {{21{fetch_inst[31]}}, fetch_inst[30:25],
                                     fetch_inst[11:7]};
         default:   dec_entry.imm = {{21{fetch_inst[31]}}, fetch_inst[30:20]};
      endcase
      // Only SLLI/SRLI/SRAI carry a zero-extended shamt; funct7 lives in [31:25]
      if (fetch_inst[6:0] == OP_IMM && fetch_inst[13:12] == 2'b01)
         dec_entry.imm = {27'b0, fetch_inst[24:20]};
      dec_entry.pc_b_fail = fetch_pred ? fetch_pc + 32'd4 : fetch_pc + dec_entry.imm;
      dec_entry.need_lsb  = (fetch_inst[6:0] == OP_LOAD) || (fetch_inst[6:0] == OP_STORE);
      dec_entry.illegal   = !(fetch_inst[6:0] inside {OP_REG, OP_IMM, OP_LOAD, OP_JALR,
                              OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL});
   end

   assign fetch_ready    = rst_in && rdy_in && !flush_in &&
                           (count_reg != (PTR_W+1)'(DEPTH));
   assign enq            = fetch_valid && fetch_ready;
   assign redirect_valid = enq && (dec_entry.opcode == OP_JAL ||
                                   (dec_entry.opcode == OP_BRANCH && fetch_pred));
   assign redirect_pc    = fetch_pc + dec_entry.imm;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t slot_reg;
         always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in)
               slot_reg <= '0;
            else if (rdy_in && enq && tail_reg == PTR_W'(gi))
               slot_reg <= dec_entry;
         end
         assign slot_q[gi] = slot_reg;
      end
   endgenerate

   assign head_entry      = slot_q[head_reg];
   assign issue_valid     = (count_reg != '0);
   assign issue_stall     = RoB_full || RoB_stall ||
                            (head_entry.need_lsb ? LSB_full : RS_full);
   assign deq             = issue_valid && !issue_stall && rdy_in && !flush_in;
   assign issue_opcode    = head_entry.opcode;
   assign issue_rd        = head_entry.rd;
   assign issue_rs1       = head_entry.rs1;
   assign issue_rs2       = head_entry.rs2;
   assign issue_funct3    = head_entry.funct3;
   assign issue_funct7    = head_entry.funct7;
   assign issue_imm       = head_entry.imm;
   assign issue_pc        = head_entry.pc;
   assign issue_pred      = head_entry.pred;
   assign issue_pc_B_fail = head_entry.pc_b_fail;
   assign issue_need_LSB  = head_entry.need_lsb;
   assign issue_illegal   = head_entry.illegal;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (rdy_in) begin
         if (flush_in) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
         end else begin
            if (enq) tail_next = tail_reg + 1'b1;
            if (deq) head_next = head_reg + 1'b1;
            case ({enq, deq})
               2'b10:   count_next = count_reg + 1'b1;
               2'b01:   count_next = count_reg - 1'b1;
               default: count_next = count_reg;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

endmodule
